gaussian_sep_filter: RTL and testbench

- Streaming separable 5x5 Gaussian blur: horizontal 5-tap pass, then vertical 5-tap pass over four line buffers.
- Parametrised in pixel width, image width and coefficients.
- Adds valid qualification, start-of-frame alignment, rounding, saturation, border flagging and a bypass mode.
- Sits between the pixel source and the DoG/scale-space stage of the SIFT pipeline.

---
 rtl/gaussian_pkg.sv | 23 ++
 rtl/line_buffer.sv | 55 +++++
 rtl/gaussian_sep_filter.sv | 203 ++++++++++++++++++++
 tb/tb_gaussian_sep_filter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gaussian_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : gaussian_pkg                                               |
// | Purpose : Default Gaussian weights/normalisation for the separable   |
// |           5x5 blur and a helper that checks the weight sum.          |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package gaussian_pkg;

  localparam int unsigned DEF_K0    = 6;
  localparam int unsigned DEF_K1    = 58;
  localparam int unsigned DEF_K2    = 128;
  localparam int unsigned DEF_SHIFT = 8;

  // 1-D kernel [K0 K1 K2 K1 K0] must sum to exactly 2**SHIFT so that a
  // flat input reproduces itself after normalisation.
  function automatic bit weights_ok(input int unsigned k0, input int unsigned k1,
                                    input int unsigned k2, input int unsigned shift);
    return ((2 * k0) + (2 * k1) + k2) == (32'd1 << shift);
  endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : line_buffer                                                |
// | Purpose : Circular RAM delay line. Each ce writes din_i and advances |
// |           the pointer; dout_o is the sample written DEPTH ce's ago.  |
// | Ports   : clk, rst   - clock, async active-high reset (pointer only) |
// |           ce         - advance enable                                |
// |           din_i      - sample to store                               |
// |           dout_o     - sample delayed by DEPTH advances              |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module line_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     ptr_q;
  logic [AW-1:0]     ptr_d;

  // Read-before-write at the same address gives exactly DEPTH samples of delay.
  assign dout_o = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (ce) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // RAM contents are deliberately not reset; stale lines are masked downstream.
  always_ff @(posedge clk) begin
    if (ce) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gaussian_sep_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gaussian_sep_filter                                        |
// | Purpose : Streaming separable 5x5 Gaussian blur. Horizontal 5-tap    |
// |           pass on the raw stream, vertical 5-tap pass across four    |
// |           line buffers, rounding/saturation, border flag, bypass.    |
// | Ports   : clk, rst    - clock, async active-high reset               |
// |           in_valid    - din/in_sof/bypass qualified                  |
// |           in_sof      - pixel is row 0, col 0 of a frame             |
// |           din         - raster-order pixel                           |
// |           bypass      - pass din through with filter latency         |
// |           out_valid   - in_valid delayed 3 cycles                    |
// |           dout        - filtered (or bypassed) pixel                 |
// |           out_border  - 5x5 window reached outside the frame         |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module gaussian_sep_filter
  import gaussian_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 400,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned K0     = DEF_K0,
  parameter int unsigned K1     = DEF_K1,
  parameter int unsigned K2     = DEF_K2,
  parameter int unsigned SHIFT  = DEF_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] din,
  input  logic              bypass,
  output logic              out_valid,
  output logic [DATA_W-1:0] dout,
  output logic              out_border
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned SUM_W  = DATA_W + COEF_W + 3;
  localparam int unsigned CNT_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [COEF_W-1:0] C_K0  = COEF_W'(K0);
  localparam logic [COEF_W-1:0] C_K1  = COEF_W'(K1);
  localparam logic [COEF_W-1:0] C_K2  = COEF_W'(K2);
  localparam logic [SUM_W-1:0]  C_RND = SUM_W'(1) << (SHIFT - 1);
  localparam logic [DATA_W-1:0] C_MAX = '1;

  if (!weights_ok(K0, K1, K2, SHIFT)) begin : g_bad_weights
    $error("gaussian_sep_filter: 2*K0+2*K1+K2 must equal 2**SHIFT");
  end
  if (IMG_W < 5) begin : g_bad_width
    $error("gaussian_sep_filter: IMG_W must be at least 5");
  end

  function automatic logic [PROD_W-1:0] mul(input logic [DATA_W-1:0] x,
                                            input logic [COEF_W-1:0] k);
    return PROD_W'(x) * PROD_W'(k);
  endfunction

  // Symmetric 5-tap MAC with round-half-up, normalise and clamp.
  function automatic logic [DATA_W-1:0] tap5(input logic [DATA_W-1:0] a0,
                                             input logic [DATA_W-1:0] a1,
                                             input logic [DATA_W-1:0] a2,
                                             input logic [DATA_W-1:0] a3,
                                             input logic [DATA_W-1:0] a4);
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  shifted;
    logic [DATA_W-1:0] res;
    sum = SUM_W'(mul(a0, C_K0)) + SUM_W'(mul(a1, C_K1)) + SUM_W'(mul(a2, C_K2))
        + SUM_W'(mul(a3, C_K1)) + SUM_W'(mul(a4, C_K0)) + C_RND;
    shifted = sum >> SHIFT;
    if (shifted > SUM_W'(C_MAX)) begin
      res = C_MAX;
    end else begin
      res = shifted[DATA_W-1:0];
    end
    return res;
  endfunction

  // ---------------- position counters ----------------
  logic [CNT_W-1:0] col_q, col_d, cur_col;
  logic [2:0]       row_q, row_d, cur_row;
  logic             border_in;

  always_comb begin
    // in_sof overrides the running count, including a pending column wrap.
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (cur_col == CNT_W'(IMG_W - 1)) begin
        col_d = '0;
        // Row only feeds the border test, so it saturates at 4.
        row_d = (cur_row == 3'd4) ? 3'd4 : cur_row + 3'd1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
    border_in = (cur_row < 3'd4) || (cur_col < CNT_W'(4));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // ---------------- stage 1: horizontal ----------------
  logic [DATA_W-1:0] s1_q, s2_q, s3_q, s4_q;
  logic [DATA_W-1:0] hq_q, pix1_q;
  logic              vld1_q, bord1_q, byp1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      s4_q    <= '0;
      hq_q    <= '0;
      pix1_q  <= '0;
      vld1_q  <= 1'b0;
      bord1_q <= 1'b0;
      byp1_q  <= 1'b0;
    end else begin
      vld1_q <= in_valid;
      if (in_valid) begin
        hq_q    <= tap5(din, s1_q, s2_q, s3_q, s4_q);
        s1_q    <= din;
        s2_q    <= s1_q;
        s3_q    <= s2_q;
        s4_q    <= s3_q;
        pix1_q  <= din;
        bord1_q <= border_in;
        byp1_q  <= bypass;
      end
    end
  end

  // ---------------- line buffer chain ----------------
  // lb_tap[0] is the current row's horizontal result; lb_tap[i] is i rows up.
  logic [DATA_W-1:0] lb_tap [5];
  assign lb_tap[0] = hq_q;

  for (genvar i = 0; i < 4; i++) begin : g_lb
    line_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W)
    ) u_lb (
      .clk    (clk),
      .rst    (rst),
      .ce     (vld1_q),
      .din_i  (lb_tap[i]),
      .dout_o (lb_tap[i+1])
    );
  end

  // ---------------- stage 2: vertical ----------------
  logic [DATA_W-1:0] vq_q, pix2_q;
  logic              vld2_q, bord2_q, byp2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vq_q    <= '0;
      pix2_q  <= '0;
      vld2_q  <= 1'b0;
      bord2_q <= 1'b0;
      byp2_q  <= 1'b0;
    end else begin
      vld2_q <= vld1_q;
      if (vld1_q) begin
        vq_q    <= tap5(lb_tap[0], lb_tap[1], lb_tap[2], lb_tap[3], lb_tap[4]);
        pix2_q  <= pix1_q;
        bord2_q <= bord1_q;
        byp2_q  <= byp1_q;
      end
    end
  end

  // ---------------- stage 3: output ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      dout       <= '0;
      out_border <= 1'b0;
    end else begin
      out_valid <= vld2_q;
      if (vld2_q) begin
        out_border <= bord2_q;
        // Bypass wins over border masking; border windows hold stale data.
        dout <= byp2_q ? pix2_q : (bord2_q ? '0 : vq_q);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gaussian_sep_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_gaussian_sep_filter                                     |
// | Purpose : Directed self-checking bench for gaussian_sep_filter with  |
// |           IMG_W=16: flat frames, impulse table, idle gaps, mid-frame |
// |           start-of-frame with bypass, and asynchronous reset.        |
// | Rev     : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_gaussian_sep_filter;

  localparam int W = 16;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] din;
  logic       bypass;
  logic       out_valid;
  logic [7:0] dout;
  logic       out_border;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gaussian_sep_filter #(
    .DATA_W (8),
    .IMG_W  (W),
    .COEF_W (8),
    .K0     (6),
    .K1     (58),
    .K2     (128),
    .SHIFT  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .din        (din),
    .bypass     (bypass),
    .out_valid  (out_valid),
    .dout       (dout),
    .out_border (out_border)
  );

  typedef struct {
    int r;
    int c;
    int d;
    int b;
  } vec_t;

  vec_t tab[16];

  int total = 0;
  int bad   = 0;

  logic [2:0] vh;
  int cap_n, acc_n;
  int cap_d   [2048];
  int cap_b   [2048];
  int acc_d   [2048];
  int ref_d   [2048];
  int ref_b   [2048];
  int ref_n;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pix(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return 255;
      2:       return (r == 4 && c == 4) ? 255 : 0;
      default: return 50;
    endcase
  endfunction

  // One clock: sample outputs on the falling edge, then drive the next inputs.
  task automatic step(input bit v, input bit s, input int d, input bit b);
    @(negedge clk);
    chk("out_valid_delay", int'(out_valid), int'(vh[2]));
    if (out_valid && cap_n < 2048) begin
      cap_d[cap_n] = int'(dout);
      cap_b[cap_n] = int'(out_border);
      cap_n++;
    end
    vh       = {vh[1:0], v};
    in_valid = v;
    in_sof   = s;
    din      = 8'(d);
    bypass   = b;
    if (v && acc_n < 2048) begin
      acc_d[acc_n] = d;
      acc_n++;
    end
  endtask

  task automatic send_frame(input int kind, input int rows, input int gap, input bit sof);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < W; c++) begin
        int idle;
        idle = 0;
        while (gap > 0 && idle < 8 && $urandom_range(0, 99) < gap) begin
          step(1'b0, 1'b0, 0, 1'b0);
          idle++;
        end
        step(1'b1, sof && r == 0 && c == 0, pix(kind, r, c), 1'b0);
      end
    end
  endtask

  task automatic drain();
    repeat (4) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic check_flat(input string nm, input int rows, input int val);
    chk({nm, " count"}, cap_n, rows * W);
    for (int i = 0; i < rows * W; i++) begin
      int eb;
      eb = ((i / W) < 4 || (i % W) < 4) ? 1 : 0;
      chk($sformatf("%s border[%0d]", nm, i), cap_b[i], eb);
      chk($sformatf("%s dout[%0d]", nm, i), cap_d[i], (eb == 1) ? 0 : val);
    end
  endtask

  initial begin
    // Impulse 255 at (4,4): output at (r,c) is the window centred (r-2,c-2).
    tab[0]  = '{6, 6, 64, 0};
    tab[1]  = '{8, 6, 3, 0};
    tab[2]  = '{8, 8, 0, 0};
    tab[3]  = '{7, 6, 29, 0};
    tab[4]  = '{6, 7, 29, 0};
    tab[5]  = '{7, 7, 13, 0};
    tab[6]  = '{8, 7, 1, 0};
    tab[7]  = '{6, 8, 3, 0};
    tab[8]  = '{7, 8, 1, 0};
    tab[9]  = '{5, 5, 13, 0};
    tab[10] = '{6, 5, 29, 0};
    tab[11] = '{4, 6, 3, 0};
    tab[12] = '{6, 4, 3, 0};
    tab[13] = '{9, 6, 0, 0};
    tab[14] = '{3, 6, 0, 1};
    tab[15] = '{6, 3, 0, 1};

    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; din = '0; bypass = 1'b0;
    vh = '0; cap_n = 0; acc_n = 0; ref_n = 0;

    // Reset state
    #7;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset dout", int'(dout), 0);
    chk("reset out_border", int'(out_border), 0);
    @(negedge clk);
    rst = 1'b0;

    // Flat 100 frame
    cap_n = 0; acc_n = 0;
    send_frame(0, 6, 0, 1'b1);
    drain();
    check_flat("flat100", 6, 100);

    // Flat 255 frame: rounding must not overflow
    cap_n = 0; acc_n = 0;
    send_frame(1, 6, 0, 1'b1);
    drain();
    check_flat("flat255", 6, 255);

    // Impulse, continuous
    cap_n = 0; acc_n = 0;
    send_frame(2, 10, 0, 1'b1);
    drain();
    chk("impulse count", cap_n, 10 * W);
    foreach (tab[k]) begin
      int idx;
      idx = tab[k].r * W + tab[k].c;
      chk($sformatf("impulse dout(%0d,%0d)", tab[k].r, tab[k].c), cap_d[idx], tab[k].d);
      chk($sformatf("impulse border(%0d,%0d)", tab[k].r, tab[k].c), cap_b[idx], tab[k].b);
    end
    ref_n = cap_n;
    for (int i = 0; i < ref_n; i++) begin
      ref_d[i] = cap_d[i];
      ref_b[i] = cap_b[i];
    end

    // Impulse with ~30% idle cycles: sequence must match the continuous run
    cap_n = 0; acc_n = 0;
    send_frame(2, 10, 30, 1'b1);
    drain();
    chk("gaps count", cap_n, ref_n);
    for (int i = 0; i < ref_n; i++) begin
      chk($sformatf("gaps dout[%0d]", i), cap_d[i], ref_d[i]);
      chk($sformatf("gaps border[%0d]", i), cap_b[i], ref_b[i]);
    end

    // Mid-frame sof at (2,5), then bypass for row 4 of the restarted frame
    cap_n = 0; acc_n = 0;
    for (int i = 0; i < 2 * W + 5; i++) step(1'b1, i == 0, 50, 1'b0);
    for (int i = 0; i < 6 * W; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      if (r == 4) step(1'b1, 1'b0, c * 9 + 3, 1'b1);
      else        step(1'b1, i == 0, 50, 1'b0);
    end
    drain();
    chk("sof count", cap_n, 2 * W + 5 + 6 * W);
    for (int i = 0; i < 6 * W; i++) begin
      int idx, r, c;
      idx = 2 * W + 5 + i;
      r = i / W;
      c = i % W;
      if (r < 4) begin
        chk($sformatf("sof border[%0d]", i), cap_b[idx], 1);
        chk($sformatf("sof dout[%0d]", i), cap_d[idx], 0);
      end else begin
        chk($sformatf("sof border[%0d]", i), cap_b[idx], (c < 4) ? 1 : 0);
        if (r == 4) chk($sformatf("bypass dout[%0d]", i), cap_d[idx], acc_d[idx]);
      end
    end

    // Asynchronous reset mid-stream while in_valid=1
    cap_n = 0; acc_n = 0;
    for (int i = 0; i < 4 * W + 13; i++) step(1'b1, i == 0, 100, 1'b0);
    chk("pre-reset out_valid", int'(out_valid), 1);
    chk("pre-reset dout", int'(dout), 100);
    #2 rst = 1'b1;
    #1;
    chk("async reset out_valid", int'(out_valid), 0);
    chk("async reset dout", int'(dout), 0);
    chk("async reset out_border", int'(out_border), 0);
    in_valid = 1'b0;
    vh = '0;
    @(negedge clk);
    rst = 1'b0;

    // First frame after reset (no sof): rows 0-3 flagged, row 4 filtered
    cap_n = 0; acc_n = 0;
    send_frame(0, 5, 0, 1'b0);
    drain();
    check_flat("post-reset", 5, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
